// File: rtl/da2_sample_streamer_if.sv
// da2_sample_streamer_if
//   Link between the sample streamer and the Pmod DA2 serial interface.
//   The streamer offers value/chmode with a level update request. The DA2
//   side answers with SYNC (request seen) and working (shift in progress).
interface da2_sample_streamer_if;
  logic [11:0] value;
  logic [1:0]  chmode;
  logic        update;
  logic        sync_in;
  logic        working_in;

  // streamer side
  modport master (
    output value,
    output chmode,
    output update,
    input  sync_in,
    input  working_in
  );

  // DA2 interface side
  modport slave (
    input  value,
    input  chmode,
    input  update,
    output sync_in,
    output working_in
  );
endinterface

// File: rtl/da2_sample_streamer.sv
// da2_sample_streamer
//   Upstream feeder for the Pmod DA2 serial interface. Samples are queued in
//   a FIFO and released one per PERIOD clocks. Each released sample is held
//   on value/chmode with update raised until the DA2 reports SYNC, then the
//   streamer waits for the DA2 working flag to rise and fall before it will
//   offer the next sample, so a transfer is never cut short.
//
//   Optional feature macro: DA2_STREAM_STATS_EN
//     When defined, adds saturating miss_cnt / sent_cnt statistics ports.
//     When undefined, those ports and counters do not exist.
module da2_sample_streamer #(
  parameter int DEPTH  = 16,
  parameter int PERIOD = 1000,
  parameter int CNT_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [11:0]              wr_data,
  input  logic [1:0]               chmode_cfg,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
`ifdef DA2_STREAM_STATS_EN
  output logic [15:0]              miss_cnt,
  output logic [15:0]              sent_cnt,
`endif
  da2_sample_streamer_if.master    da2
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_ZERO  = LVL_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ARM  = 2'd2,
    ST_BUSY = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                underrun_q, underrun_d;
  logic [11:0]         value_q, value_d;
  logic [1:0]          chmode_q, chmode_d;
  logic                update_q, update_d;
  logic [11:0]         mem_q [DEPTH];

  // ---------------------------------------------------------------------
  // Events decoded each cycle
  // ---------------------------------------------------------------------
  logic tick;      // timer reached the end of a sample period
  logic push;      // FIFO write accepted
  logic pop;       // FIFO head handed to the DA2 side
  logic consume;   // pending tick used up by the FSM in IDLE
  logic under_ev;  // pending tick found the FIFO empty
  logic drop_ev;   // tick arrived while one was already pending
  logic sent_ev;   // DA2 acknowledged a request with SYNC

  // Saturating 16-bit increment by 0, 1 or 2.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    if (sum[16]) begin
      sat_add16 = 16'hFFFF;
    end else begin
      sat_add16 = sum[15:0];
    end
  endfunction

  assign tick    = en & (cnt_q == CNT_LAST);
  assign push    = wr_en & ~full_q;
  assign drop_ev = tick & pend_q & ~flush;

  // Sample-period timer: free-runs 0..PERIOD-1 while enabled, parked at 0 otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Transfer FSM: pop on a pending tick, hold update until SYNC, then track working.
  always_comb begin
    state_d  = state_q;
    update_d = update_q;
    value_d  = value_q;
    chmode_d = chmode_q;
    pop      = 1'b0;
    consume  = 1'b0;
    under_ev = 1'b0;
    sent_ev  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // flush in the same cycle wins: the tick is discarded, nothing popped
        if (pend_q && en && !flush) begin
          consume = 1'b1;
          if (!empty_q) begin
            pop      = 1'b1;
            value_d  = mem_q[rd_ptr_q];
            chmode_d = chmode_cfg;
            update_d = 1'b1;
            state_d  = ST_REQ;
          end else begin
            // nothing to send: outputs keep the last sample
            under_ev = 1'b1;
            state_d  = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (da2.sync_in) begin
          update_d = 1'b0;
          sent_ev  = 1'b1;
          state_d  = ST_ARM;
        end else begin
          update_d = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_ARM: begin
        if (da2.working_in) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_BUSY: begin
        if (!da2.working_in) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        update_d = 1'b0;
      end
    endcase
  end

  // Pending-tick flag: one tick may wait for the FSM, extra ticks are dropped.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = 1'b0;
    end else if (consume) begin
      pend_d = 1'b0;
    end else if (tick) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // FIFO pointers, occupancy and status flags; flush empties without touching the FSM.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = LVL_ZERO;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ADDR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ADDR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == LVL_ZERO);
  end

  // Sticky underrun indication, cleared only by flush or reset.
  always_comb begin
    underrun_d = underrun_q;
    if (flush) begin
      underrun_d = 1'b0;
    end else if (under_ev) begin
      underrun_d = 1'b1;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Sample storage: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Control and output registers; reset drops update immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= LVL_ZERO;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      underrun_q <= 1'b0;
      value_q    <= 12'd0;
      chmode_q   <= 2'd0;
      update_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      underrun_q <= underrun_d;
      value_q    <= value_d;
      chmode_q   <= chmode_d;
      update_q   <= update_d;
    end
  end

`ifdef DA2_STREAM_STATS_EN
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic [15:0] sent_cnt_q, sent_cnt_d;

  // Statistics: missed ticks (dropped or underrun) and acknowledged transfers.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    sent_cnt_d = sent_cnt_q;
    if (flush) begin
      miss_cnt_d = 16'd0;
      sent_cnt_d = 16'd0;
    end else begin
      miss_cnt_d = sat_add16(miss_cnt_q, {1'b0, drop_ev} + {1'b0, under_ev});
      sent_cnt_d = sat_add16(sent_cnt_q, {1'b0, sent_ev});
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt_q <= 16'd0;
      sent_cnt_q <= 16'd0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

  assign miss_cnt = miss_cnt_q;
  assign sent_cnt = sent_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = drop_ev ^ sent_ev;
`endif

  assign full       = full_q;
  assign empty      = empty_q;
  assign level      = level_q;
  assign underrun   = underrun_q;
  assign da2.value  = value_q;
  assign da2.chmode = chmode_q;
  assign da2.update = update_q;

endmodule

// File: tb/tb_da2_sample_streamer.sv
// tb_da2_sample_streamer
//   Directed bench: a small DA2 responder answers update with SYNC after a
//   programmable delay and then holds working for a programmable time.
//   Expected samples go into a queue when pushed; a monitor pops and
//   compares them on every rising edge of update.
module tb_da2_sample_streamer;
  localparam int DEPTH  = 16;
  localparam int PERIOD = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [11:0] wr_data = 12'd0;
  logic [1:0]  chmode_cfg = 2'd0;
  logic        full, empty, underrun;
  logic [4:0]  level;
`ifdef DA2_STREAM_STATS_EN
  logic [15:0] miss_cnt, sent_cnt;
`endif

  da2_sample_streamer_if ifc ();

  da2_sample_streamer #(.DEPTH(DEPTH), .PERIOD(PERIOD), .CNT_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .chmode_cfg (chmode_cfg),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .underrun   (underrun),
`ifdef DA2_STREAM_STATS_EN
    .miss_cnt   (miss_cnt),
    .sent_cnt   (sent_cnt),
`endif
    .da2        (ifc)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [13:0] exp_q [$];
  int          rise_cnt = 0;
  int          rise_cyc [$];
  int          hi_run = 0;
  int          last_hi = 0;
  int          wfall_cyc = 0;
  int          sync_delay = 2;
  int          work_len = 10;
  int          en_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // scoreboard monitor: compare each newly offered sample, measure update width
  initial begin
    logic        prev;
    logic [13:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev   = 1'b0;
        hi_run = 0;
      end else begin
        if (ifc.update && !prev) begin
          rise_cnt++;
          rise_cyc.push_back(cyc);
          hi_run = 1;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got value %h, expected no sample", ifc.value);
          end else begin
            e = exp_q.pop_front();
            chk("sb_value", 32'(ifc.value), 32'(e[11:0]));
            chk("sb_chmode", 32'(ifc.chmode), 32'(e[13:12]));
          end
        end else if (ifc.update) begin
          hi_run++;
        end else if (prev) begin
          last_hi = hi_run;
        end
        prev = ifc.update;
      end
    end
  end

  // DA2 responder model
  initial begin
    int sd;
    int wl;
    ifc.sync_in    = 1'b0;
    ifc.working_in = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.update) begin
        sd = sync_delay;
        wl = work_len;
        repeat (sd) @(negedge clk);
        ifc.sync_in = 1'b1;
        @(negedge clk);
        ifc.sync_in    = 1'b0;
        ifc.working_in = 1'b1;
        repeat (wl) @(negedge clk);
        ifc.working_in = 1'b0;
        wfall_cyc = cyc;
      end
    end
  end

  // push one sample; called at a negedge, returns at the next negedge
  task automatic push(input logic [11:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rise(input int target, input int budget);
    int k;
    k = 0;
    while (rise_cnt < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("rise_timeout", 32'(rise_cnt >= target), 32'd1);
  endtask

  task automatic wait_update_low(input int budget);
    int k;
    k = 0;
    while (ifc.update && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("update_low_timeout", 32'(ifc.update), 32'd0);
  endtask

  initial begin
    int k;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_update", 32'(ifc.update), 32'd0);
    chk("rst_value", 32'(ifc.value), 32'd0);
    chk("rst_chmode", 32'(ifc.chmode), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: three samples at the sample rate, then underrun
    sync_delay = 2;
    work_len   = 10;
    chmode_cfg = 2'd0;
    push(12'h123); exp_q.push_back({2'd0, 12'h123});
    push(12'h456); exp_q.push_back({2'd0, 12'h456});
    push(12'hFFF); exp_q.push_back({2'd0, 12'hFFF});
    chk("t1_level", 32'(level), 32'd3);
    en     = 1'b1;
    en_cyc = cyc;
    wait_rise(3, 200);
    chk("t1_first_latency", 32'(rise_cyc[0] - en_cyc), 32'(PERIOD + 1));
    chk("t1_interval_a", 32'(rise_cyc[1] - rise_cyc[0]), 32'(PERIOD));
    chk("t1_interval_b", 32'(rise_cyc[2] - rise_cyc[1]), 32'(PERIOD));
    chk("t1_update_width", 32'(last_hi), 32'd3);
    repeat (PERIOD - 1) @(negedge clk);
    #1;
    chk("t1_underrun_before_tick", 32'(underrun), 32'd0);
    @(negedge clk);
    #1;
    chk("t1_underrun", 32'(underrun), 32'd1);
    chk("t1_empty", 32'(empty), 32'd1);
`ifdef DA2_STREAM_STATS_EN
    chk("t1_miss_cnt", 32'(miss_cnt), 32'd1);
    chk("t1_sent_cnt", 32'(sent_cnt), 32'd3);
`endif
    en = 1'b0;
    pulse_flush();
    chk("t1_flush_underrun", 32'(underrun), 32'd0);

    // 2: overfill with the timer stopped
    chmode_cfg = 2'd1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(12'(16'h100 + i));
      if (i < DEPTH) exp_q.push_back({2'd1, 12'(16'h100 + i)});
      if (i == DEPTH - 2) begin
        chk("t2_not_full", 32'(full), 32'd0);
        chk("t2_level_m1", 32'(level), 32'(DEPTH - 1));
      end
      if (i == DEPTH - 1) chk("t2_full", 32'(full), 32'd1);
    end
    chk("t2_full_after_extra", 32'(full), 32'd1);
    chk("t2_level", 32'(level), 32'(DEPTH));

    // 3: SYNC five cycles after update
    sync_delay = 5;
    work_len   = 10;
    en = 1'b1;
    wait_rise(4, 100);
    sync_delay = 1;
    work_len   = 90;
    wait_update_low(20);
    chk("t3_update_width", 32'(last_hi), 32'd6);

    // 4: working held across two ticks
    wait_rise(5, 100);
    sync_delay = 1;
    work_len   = 30;
    wait_rise(6, 200);
    chk("t4_pop_first_idle", 32'(rise_cyc[5] - wfall_cyc), 32'd2);
`ifdef DA2_STREAM_STATS_EN
    chk("t4_miss_cnt", 32'(miss_cnt), 32'd1);
    chk("t4_sent_cnt", 32'(sent_cnt), 32'd2);
`endif
    en = 1'b0;

    // 5: flush while BUSY with five samples queued
    exp_q.delete();
    repeat (3) @(negedge clk);
    pulse_flush();
    for (int i = 0; i < 5; i++) push(12'(16'h200 + i));
    chk("t5_level_pre", 32'(level), 32'd5);
    chk("t5_working", 32'(ifc.working_in), 32'd1);
    pulse_flush();
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_underrun", 32'(underrun), 32'd0);
    chk("t5_value_hold", 32'(ifc.value), 32'h102);
    chk("t5_chmode_hold", 32'(ifc.chmode), 32'd1);
    k = 0;
    while (ifc.working_in && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("t5_working_timeout", 32'(ifc.working_in), 32'd0);
    repeat (2) @(negedge clk);

    // 6: reset while REQ (also proves the flushed transfer returned to IDLE)
    sync_delay = 20;
    work_len   = 5;
    chmode_cfg = 2'd2;
    push(12'h3AB); exp_q.push_back({2'd2, 12'h3AB});
    push(12'h3CD);
    en = 1'b1;
    wait_rise(7, 60);
    repeat (3) @(negedge clk);
    chk("t6_in_req", 32'(ifc.update), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_update_async", 32'(ifc.update), 32'd0);
    chk("t6_level_async", 32'(level), 32'd0);
    chk("t6_empty_async", 32'(empty), 32'd1);
    chk("t6_value_async", 32'(ifc.value), 32'd0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    sync_delay = 2;
    work_len   = 5;
    push(12'h0AA); exp_q.push_back({2'd2, 12'h0AA});
    en = 1'b1;
    wait_rise(8, 60);
    repeat (20) @(negedge clk);
    en = 1'b0;

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("rise_total", 32'(rise_cnt), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // hard stop in case the sequence above ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected sequence completion");
    $fatal(1, "watchdog");
  end
endmodule
